// File: rtl/cdp_mul_pkg.sv
// Shared constants and the rounding right-shift used by the CDP multiply stage.
package cdp_mul_pkg;

  localparam int LANES_DEF = 4;
  localparam int A_W_DEF   = 9;
  localparam int SH_W_DEF  = 5;
  localparam int OUT_W     = A_W_DEF + 16;

  // Arithmetic right shift with round-half-up; shifts of w or more collapse to the sign.
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] p,
                                                     input logic [31:0] sh,
                                                     input logic [31:0] w);
    logic signed [63:0] res;
    if (sh >= w) begin
      res = p[63] ? -64'sd1 : 64'sd0;
    end else if (sh == 32'd0) begin
      res = p;
    end else begin
      res = (p + (64'sd1 <<< (sh - 32'd1))) >>> sh;
    end
    return res;
  endfunction

endpackage

// File: rtl/cdp_dp_mul_pipe_lane.sv
// One lane of the CDP multiply pipeline: product (or bypass extend) in stage 0,
// saturate/round/shift in stage 1, plain register copies after that.
module cdp_mul_lane
  import cdp_mul_pkg::*;
#(
  parameter int A_W  = A_W_DEF,
  parameter int SH_W = SH_W_DEF,
  parameter int LAT  = 2
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rst,
  input  logic [LAT-1:0]    stage_en,
  input  logic              mode,
  input  logic [SH_W-1:0]   shift,
  input  logic [A_W-1:0]    data,
  input  logic [16:0]       coef,
  output logic [A_W+15:0]   result
);

  localparam int LANE_W = A_W + 16;

  logic signed [LANE_W-1:0] a_ext;
  logic signed [LANE_W-1:0] b_ext;
  logic signed [LANE_W-1:0] prod;
  logic signed [LANE_W-1:0] bypass_ext;
  logic        [LANE_W-1:0] in_word;
  logic        [LANE_W-1:0] stage_q [LAT];

  assign a_ext      = {{16{data[A_W-1]}}, data};
  assign b_ext      = {{A_W{coef[15]}}, coef[15:0]};
  assign prod       = a_ext * b_ext;
  assign bypass_ext = {{(LANE_W-17){coef[16]}}, coef};
  assign in_word    = mode ? bypass_ext : prod;

  function automatic logic [LANE_W-1:0] finish_word(input logic [LANE_W-1:0] w,
                                                    input logic sat,
                                                    input logic [SH_W-1:0] sh,
                                                    input logic byp);
    logic [LANE_W-1:0] res;
    if (byp) begin
      res = w;
    end else if (sat) begin
      res = {1'b0, {(LANE_W-1){1'b1}}};
    end else begin
      res = LANE_W'(round_shift({{(64-LANE_W){w[LANE_W-1]}}, w},
                                {{(32-SH_W){1'b0}}, sh}, 32'(LANE_W)));
    end
    return res;
  endfunction

  generate
    if (LAT == 1) begin : g_merged
      always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
          stage_q[0] <= '0;
        end else if (stage_en[0]) begin
          stage_q[0] <= finish_word(in_word, coef[16], shift, mode);
        end
      end
    end else begin : g_split
      // Stage 0 keeps the beat's saturate flag, shift and mode tag beside the product.
      logic            s0_sat;
      logic            s0_mode;
      logic [SH_W-1:0] s0_shift;

      always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
          for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
          s0_sat   <= 1'b0;
          s0_mode  <= 1'b0;
          s0_shift <= '0;
        end else begin
          if (stage_en[0]) begin
            stage_q[0] <= in_word;
            s0_sat     <= coef[16];
            s0_mode    <= mode;
            s0_shift   <= shift;
          end
          if (stage_en[1]) begin
            stage_q[1] <= finish_word(stage_q[0], s0_sat, s0_shift, s0_mode);
          end
          for (int i = 2; i < LAT; i++) begin
            if (stage_en[i]) stage_q[i] <= stage_q[i-1];
          end
        end
      end
    end
  endgenerate

  assign result = stage_q[LAT-1];

endmodule

// File: rtl/cdp_dp_mul_pipe.sv
// CDP multiply stage: joins intp2mul and sync2mul beats, multiplies (or bypasses)
// LANES lanes through a LAT-deep elastic pipeline, with drained mode switching.
module cdp_dp_mul_pipe
  import cdp_mul_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int A_W   = A_W_DEF,
  parameter int LAT   = 2,
  parameter int SH_W  = SH_W_DEF
) (
  input  logic                       nvdla_core_clk,
  input  logic                       nvdla_core_rst,
  input  logic                       intp2mul_pvld,
  output logic                       intp2mul_prdy,
  input  logic [LANES*17-1:0]        intp2mul_pd,
  input  logic                       sync2mul_pvld,
  output logic                       sync2mul_prdy,
  input  logic [LANES*A_W-1:0]       sync2mul_pd,
  input  logic                       reg2dp_mul_bypass,
  input  logic [SH_W-1:0]            reg2dp_mul_shift,
  output logic                       mul2ocvt_pvld,
  input  logic                       mul2ocvt_prdy,
  output logic [LANES*(A_W+16)-1:0]  mul2ocvt_pd,
  output logic                       mul_busy
);

  logic [LAT-1:0] stage_v;
  logic [LAT-1:0] stage_rdy;
  logic [LAT-1:0] stage_en;
  logic           mode_q;
  logic           mode_pend;
  logic           accept;

  // A stage can take a beat when it is empty or its content moves on this cycle.
  always_comb begin
    stage_rdy          = '0;
    stage_rdy[LAT-1]   = !stage_v[LAT-1] | mul2ocvt_prdy;
    for (int i = LAT - 2; i >= 0; i--) begin
      stage_rdy[i] = !stage_v[i] | stage_rdy[i+1];
    end
  end

  always_comb begin
    stage_en    = '0;
    stage_en[0] = accept;
    for (int i = 1; i < LAT; i++) begin
      stage_en[i] = stage_v[i-1] & stage_rdy[i];
    end
  end

  assign accept        = intp2mul_pvld & sync2mul_pvld & stage_rdy[0] & !mode_pend;
  assign intp2mul_prdy = sync2mul_pvld & stage_rdy[0] & !mode_pend;
  assign sync2mul_prdy = intp2mul_pvld & stage_rdy[0] & !mode_pend;

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      stage_v <= '0;
    end else begin
      if (stage_rdy[0]) stage_v[0] <= accept;
      for (int i = 1; i < LAT; i++) begin
        if (stage_rdy[i]) stage_v[i] <= stage_v[i-1];
      end
    end
  end

  // A mode request holds off new beats and only lands once every stage is empty.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      mode_q    <= 1'b0;
      mode_pend <= 1'b0;
    end else if (mode_pend) begin
      if (reg2dp_mul_bypass == mode_q) begin
        mode_pend <= 1'b0;
      end else if (!mul_busy) begin
        mode_q    <= reg2dp_mul_bypass;
        mode_pend <= 1'b0;
      end
    end else if (reg2dp_mul_bypass != mode_q) begin
      mode_pend <= 1'b1;
    end
  end

  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      cdp_mul_lane #(
        .A_W  (A_W),
        .SH_W (SH_W),
        .LAT  (LAT)
      ) u_lane (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rst (nvdla_core_rst),
        .stage_en       (stage_en),
        .mode           (mode_q),
        .shift          (reg2dp_mul_shift),
        .data           (sync2mul_pd[g*A_W +: A_W]),
        .coef           (intp2mul_pd[g*17 +: 17]),
        .result         (mul2ocvt_pd[g*(A_W+16) +: (A_W+16)])
      );
    end
  endgenerate

  assign mul2ocvt_pvld = stage_v[LAT-1];
  assign mul_busy      = |stage_v;

endmodule

// File: doc/cdp_dp_mul_pipe.md
Name: cdp_dp_mul_pipe

Overview:
Parametrised successor of the CDP multiply stage, between the LUT interpolator (intp2mul) and the output converter (mul2ocvt).
- Joins the interpolator stream with the synced input-data stream and multiplies LANES signed pairs.
- Applies a programmable rounding right-shift.
- Offers bypass, where bypass data traverses the same LAT-deep pipeline as multiply data. Ordering and latency are therefore identical in both modes.
- Mode changes are deferred safely until the pipeline drains.

Parameters:
LANES, 4, lanes per beat (throughput).
A_W, 9, signed width of each sync2mul lane.
LAT, 2, pipeline depth in cycles, 1..4; the last stage is the output register.
SH_W, 5, width of the shift field.

Ports:
nvdla_core_clk  in  1  core clock
nvdla_core_rst  in  1  asynchronous reset, active-high
intp2mul_pvld  in  1  interpolator beat valid
intp2mul_prdy  out  1  interpolator beat ready
intp2mul_pd  in  LANES*17  per lane: [15:0] signed coefficient, [16] saturate flag
sync2mul_pvld  in  1  data beat valid
sync2mul_prdy  out  1  data beat ready
sync2mul_pd  in  LANES*A_W  per-lane signed data
reg2dp_mul_bypass  in  1  requested mode (1 = bypass)
reg2dp_mul_shift  in  SH_W  right-shift amount, sampled per accepted beat
mul2ocvt_pvld  out  1  output valid
mul2ocvt_prdy  in  1  output ready
mul2ocvt_pd  out  LANES*(A_W+16)  per-lane result, lane 0 in the LSBs
mul_busy  out  1  any pipeline stage valid

Behaviour:
Reset:
- All stage valids = 0, mode_q = 0 (multiply), mode_pend = 0.
- mul2ocvt_pvld = 0, mul2ocvt_pd = 0, mul_busy = 0.
- Reset mid-stream discards all in-flight beats.

Join:
- accept = intp2mul_pvld & sync2mul_pvld & stage0_rdy & !mode_pend.
- intp2mul_prdy = sync2mul_pvld & stage0_rdy & !mode_pend.
- sync2mul_prdy = intp2mul_pvld & stage0_rdy & !mode_pend.
- Neither side is ever consumed alone. Ready has no combinational dependency on its own valid.

Pipeline:
- LAT stages, each holding a valid bit and data.
- stage_i advances when stage_{i+1} is empty or advancing; the last stage advances on mul2ocvt_prdy.
- stage0_rdy = !v0 | adv0.
- With mul2ocvt_prdy held at 1: sustains 1 beat/cycle, accept-to-pvld latency = LAT cycles, no bubbles.
- Under backpressure: bubbles collapse, no beat is dropped or duplicated, and mul2ocvt_pd is stable while pvld & !prdy.

Lane arithmetic (mode_q = 0):
- p = $signed(a[A_W-1:0]) * $signed(b[15:0]), giving A_W+16 bits.
- Result = (p + (sh ? 1<<(sh-1) : 0)) >>> sh. The shift is arithmetic with round-half-up; the sum is computed in A_W+17 bits, then truncated.
- sh >= A_W+16 yields 0 for non-negative p and -1 for negative p.
- If b[16] = 1, the lane result is forced to +max (0 followed by all ones).
- The product is registered in stage 0 and the round/shift is applied in stage 1 (LAT = 1 merges both).

Bypass lane (mode_q = 1):
- Result = sign-extension of intp2mul_pd lane [16:0] to A_W+16 bits.
- sync2mul_pd is consumed and discarded; the shift is ignored.

Mode control:
- When reg2dp_mul_bypass != mode_q, set mode_pend = 1, which blocks accepts.
- On the first cycle with no valid stage and mode_pend = 1: mode_q <= reg2dp_mul_bypass and mode_pend <= 0. Accepts resume the next cycle.
- A request reverting before the drain completes clears mode_pend with no mode change.
- The mode travels with each beat (stage tag), so in-flight beats keep their mode.

Decomposition:
Package cdp_mul_pkg holds:
- default LANES/A_W/SH_W constants;
- the lane width localparam OUT_W = A_W+16;
- function round_shift(p, sh).

Sub-module cdp_mul_lane holds one lane's datapath (multiply, saturate-flag mux, bypass extend, round/shift) with stage-enable inputs driven by the shared control in cdp_dp_mul_pipe. It is generated LANES times.

Test Plan:
- LANES=4, A_W=9, LAT=2, sh=0, multiply mode; lane0 a=3, b=100 -> lane0 = 300 (0x000012C), pvld exactly 2 cycles after accept.
- sh=2; a=3, b=-5 (p=-15) -> lane = -4 (0x1FFFFFC); a=3, b=6 (p=18) -> 5 (4.5 rounds up).
- Bypass; intp lane0 pd = 0x10005 -> lane0 = 0x1FF0005; sync data ignored; latency still 2 cycles.
- Stream 8 beats while prdy toggles 1,0,0,1,... -> all 8 beats arrive in order, none lost or duplicated, pd stable during stalls, back-to-back output whenever prdy = 1.
- Only intp2mul_pvld asserted -> both prdy = 0 and no accept; sync2mul_pvld rises 3 cycles later -> single accept.
- Toggle reg2dp_mul_bypass with 2 beats in flight -> both prdy drop; the 2 beats exit in the old mode; mode_q flips on the first empty cycle; the next beat uses the new mode. Reset mid-stream -> pvld = 0 the next cycle and busy = 0.
